// File: rtl/branch_predictor_gshare.sv
`default_nettype none
// ============================================================================
//  Module   : branch_predictor_gshare
//  Purpose  : Fetch-stage next-PC predictor with three parts:
//             - a direct-mapped tagged BTB that records the branch type,
//             - a gshare PHT of 2-bit counters indexed by PC XOR global history,
//             - a circular return-address stack.
//             In F it predicts the next PC and speculatively updates the
//             global history and the RAS. In E it trains the tables, detects
//             mispredictions, repairs the history/RAS and raises flush.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst          clock; synchronous active-high reset
//    stall_F           F held; no speculative history/RAS update this cycle
//    pc_F, pc4_F       fetch PC and fetch PC + 4
//    pc_next, taken_F  predicted next PC and taken flag
//    ghr_F, ras_ptr_F  history / RAS pointer snapshots, carried down to E
//    branch_E, jump_E, call_E, ret_E   resolved instruction class in E
//    actual_E          resolved branch direction
//    taken_pred_E, pred_target_E       F prediction carried down to E
//    pc_E, pc_target_E, pc4_E          E PC, resolved target, E PC + 4
//    ghr_E, ras_ptr_E  snapshots carried down with the instruction
//    flush, pc_restore mispredict flag and corrected PC (0 when no flush)
// ============================================================================
module branch_predictor_gshare #(
  parameter int BTB_IDX_BITS = 10,
  parameter int TAG_BITS     = 10,
  parameter int PHT_IDX_BITS = 8,
  parameter int GHR_BITS     = 8,
  parameter int RAS_DEPTH    = 8,
  parameter int PTR_BITS     = $clog2(RAS_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall_F,
  input  logic [31:0]         pc_F,
  input  logic [31:0]         pc4_F,
  output logic [31:0]         pc_next,
  output logic                taken_F,
  output logic [GHR_BITS-1:0] ghr_F,
  output logic [PTR_BITS-1:0] ras_ptr_F,
  input  logic                branch_E,
  input  logic                jump_E,
  input  logic                call_E,
  input  logic                ret_E,
  input  logic                actual_E,
  input  logic                taken_pred_E,
  input  logic [31:0]         pred_target_E,
  input  logic [31:0]         pc_E,
  input  logic [31:0]         pc_target_E,
  input  logic [31:0]         pc4_E,
  input  logic [GHR_BITS-1:0] ghr_E,
  input  logic [PTR_BITS-1:0] ras_ptr_E,
  output logic                flush,
  output logic [31:0]         pc_restore
);

  localparam int BTB_ENTRIES = 1 << BTB_IDX_BITS;
  localparam int PHT_ENTRIES = 1 << PHT_IDX_BITS;

  localparam logic [1:0] TYPE_BR   = 2'd0;
  localparam logic [1:0] TYPE_JMP  = 2'd1;
  localparam logic [1:0] TYPE_CALL = 2'd2;
  localparam logic [1:0] TYPE_RET  = 2'd3;

  localparam logic [PTR_BITS:0]          RAS_FULL   = (PTR_BITS+1)'(RAS_DEPTH);
  localparam logic signed [PTR_BITS+2:0] RAS_FULL_S = (PTR_BITS+3)'(RAS_DEPTH);

  // Table storage
  logic                btb_valid  [BTB_ENTRIES];
  logic [TAG_BITS-1:0] btb_tag    [BTB_ENTRIES];
  logic [31:0]         btb_target [BTB_ENTRIES];
  logic [1:0]          btb_type   [BTB_ENTRIES];
  logic [1:0]          pht        [PHT_ENTRIES];
  logic [31:0]         ras_mem    [RAS_DEPTH];

  // Speculative state; ras_ptr addresses the current top-of-stack entry
  logic [GHR_BITS-1:0] ghr_spec;
  logic [PTR_BITS-1:0] ras_ptr;
  logic [PTR_BITS:0]   ras_cnt;

  // ---------------------------------------------------------------- F lookup
  logic [BTB_IDX_BITS-1:0] bidx_f;
  logic [TAG_BITS-1:0]     tag_f;
  logic [PHT_IDX_BITS-1:0] pidx_f;
  logic                    hit_f;
  logic [1:0]              type_f;
  logic [1:0]              ctr_f;
  logic                    ras_empty;
  logic [31:0]             target_f;

  assign bidx_f    = pc_F[BTB_IDX_BITS+1:2];
  assign tag_f     = pc_F[BTB_IDX_BITS+TAG_BITS+1:BTB_IDX_BITS+2];
  assign pidx_f    = pc_F[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(ghr_spec);
  assign hit_f     = btb_valid[bidx_f] && (btb_tag[bidx_f] == tag_f);
  assign type_f    = btb_type[bidx_f];
  assign ctr_f     = pht[pidx_f];
  assign ras_empty = (ras_cnt == '0);
  assign target_f  = (type_f == TYPE_RET && !ras_empty) ? ras_mem[ras_ptr] : btb_target[bidx_f];

  assign taken_F   = hit_f && ((type_f != TYPE_BR) || ctr_f[1]);
  assign pc_next   = taken_F ? target_f : pc4_F;
  assign ghr_F     = ghr_spec;
  assign ras_ptr_F = ras_ptr;

  // ------------------------------------------------------- E resolve / flush
  logic [BTB_IDX_BITS-1:0] bidx_e;
  logic [TAG_BITS-1:0]     tag_e;
  logic [PHT_IDX_BITS-1:0] pidx_e;
  logic                    mis_br;
  logic                    mis_jmp;
  logic                    call_e;
  logic                    ret_e;
  logic                    btb_we;
  logic [1:0]              type_e;

  assign bidx_e  = pc_E[BTB_IDX_BITS+1:2];
  assign tag_e   = pc_E[BTB_IDX_BITS+TAG_BITS+1:BTB_IDX_BITS+2];
  assign pidx_e  = pc_E[PHT_IDX_BITS+1:2] ^ PHT_IDX_BITS'(ghr_E);
  assign call_e  = jump_E && call_E;
  assign ret_e   = jump_E && ret_E;

  assign mis_br  = branch_E && ((taken_pred_E != actual_E) ||
                                (actual_E && (pred_target_E != pc_target_E)));
  assign mis_jmp = jump_E && (!taken_pred_E || (pred_target_E != pc_target_E));
  assign flush   = mis_br || mis_jmp;
  assign pc_restore = !flush ? 32'd0 : ((jump_E || actual_E) ? pc_target_E : pc4_E);

  assign btb_we  = (branch_E && actual_E) || jump_E;
  assign type_e  = call_e ? TYPE_CALL : (ret_e ? TYPE_RET : (jump_E ? TYPE_JMP : TYPE_BR));

  // ------------------------------------------------------------- RAS repair
  // Entries pushed/popped by F since the E snapshot show up as the pointer
  // distance ras_ptr - ras_ptr_E; removing that distance from the live count
  // gives the count as it stood at the snapshot.
  logic [PTR_BITS-1:0]          ptr_delta;
  logic signed [PTR_BITS+2:0]   cnt_diff;
  logic [PTR_BITS:0]            cnt_rest;
  logic [PTR_BITS-1:0]          rep_ptr;
  logic [PTR_BITS:0]            rep_cnt;

  always_comb begin
    ptr_delta = ras_ptr - ras_ptr_E;
    cnt_diff  = $signed({2'b00, ras_cnt}) - $signed({{3{ptr_delta[PTR_BITS-1]}}, ptr_delta});
    if (cnt_diff[PTR_BITS+2])       cnt_rest = '0;
    else if (cnt_diff > RAS_FULL_S) cnt_rest = RAS_FULL;
    else                            cnt_rest = cnt_diff[PTR_BITS:0];

    rep_ptr = ras_ptr_E;
    rep_cnt = cnt_rest;
    if (call_e) begin
      rep_ptr = ras_ptr_E + PTR_BITS'(1);
      if (cnt_rest != RAS_FULL) rep_cnt = cnt_rest + (PTR_BITS+1)'(1);
    end else if (ret_e && (cnt_rest != '0)) begin
      rep_ptr = ras_ptr_E - PTR_BITS'(1);
      rep_cnt = cnt_rest - (PTR_BITS+1)'(1);
    end
  end

  // ------------------------------------------------- speculative state update
  always_ff @(posedge clk) begin
    if (rst) begin
      ghr_spec <= '0;
      ras_ptr  <= '0;
      ras_cnt  <= '0;
    end else if (flush) begin
      ghr_spec <= branch_E ? {ghr_E[GHR_BITS-2:0], actual_E} : ghr_E;
      ras_ptr  <= rep_ptr;
      ras_cnt  <= rep_cnt;
    end else if (!stall_F && hit_f) begin
      case (type_f)
        TYPE_BR:   ghr_spec <= {ghr_spec[GHR_BITS-2:0], ctr_f[1]};
        TYPE_CALL: begin
          ras_ptr <= ras_ptr + PTR_BITS'(1);
          if (ras_cnt != RAS_FULL) ras_cnt <= ras_cnt + (PTR_BITS+1)'(1);
        end
        TYPE_RET: begin
          if (!ras_empty) begin
            ras_ptr <= ras_ptr - PTR_BITS'(1);
            ras_cnt <= ras_cnt - (PTR_BITS+1)'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // RAS data: a full stack simply wraps and overwrites its oldest entry
  logic push_e;
  logic push_f;
  assign push_e = !rst && flush && call_e;
  assign push_f = !rst && !flush && !stall_F && hit_f && (type_f == TYPE_CALL);

  always_ff @(posedge clk) begin
    if (push_e)      ras_mem[ras_ptr_E + PTR_BITS'(1)] <= pc4_E;
    else if (push_f) ras_mem[ras_ptr + PTR_BITS'(1)]   <= pc4_F;
  end

  // ---------------------------------------------------------- table training
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) btb_valid[i] <= 1'b0;
    end else if (btb_we) begin
      btb_valid[bidx_e] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && btb_we) begin
      btb_tag[bidx_e]    <= tag_e;
      btb_target[bidx_e] <= pc_target_E;
      btb_type[bidx_e]   <= type_e;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PHT_ENTRIES; i++) pht[i] <= 2'b01;
    end else if (branch_E) begin
      if (actual_E && (pht[pidx_e] != 2'b11))       pht[pidx_e] <= pht[pidx_e] + 2'b01;
      else if (!actual_E && (pht[pidx_e] != 2'b00)) pht[pidx_e] <= pht[pidx_e] - 2'b01;
    end
  end

  // PC bits outside the index/tag fields are not part of any lookup
  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_F, pc_E};

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor_gshare.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_branch_predictor_gshare
//  Purpose  : Directed self-checking bench for branch_predictor_gshare with
//             default parameters (1024-entry BTB, 256-entry PHT, 8-bit GHR,
//             8-entry RAS). Expected values are worked out by hand per step.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_branch_predictor_gshare;

  localparam int GB = 8;
  localparam int PB = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          stall_F;
  logic [31:0]   pc_F, pc4_F, pc_next;
  logic          taken_F;
  logic [GB-1:0] ghr_F;
  logic [PB-1:0] ras_ptr_F;
  logic          branch_E, jump_E, call_E, ret_E, actual_E, taken_pred_E;
  logic [31:0]   pred_target_E, pc_E, pc_target_E, pc4_E;
  logic [GB-1:0] ghr_E;
  logic [PB-1:0] ras_ptr_E;
  logic          flush;
  logic [31:0]   pc_restore;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  branch_predictor_gshare dut (
    .clk(clk), .rst(rst), .stall_F(stall_F),
    .pc_F(pc_F), .pc4_F(pc4_F), .pc_next(pc_next), .taken_F(taken_F),
    .ghr_F(ghr_F), .ras_ptr_F(ras_ptr_F),
    .branch_E(branch_E), .jump_E(jump_E), .call_E(call_E), .ret_E(ret_E),
    .actual_E(actual_E), .taken_pred_E(taken_pred_E), .pred_target_E(pred_target_E),
    .pc_E(pc_E), .pc_target_E(pc_target_E), .pc4_E(pc4_E),
    .ghr_E(ghr_E), .ras_ptr_E(ras_ptr_E),
    .flush(flush), .pc_restore(pc_restore)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic e_idle();
    branch_E = 0; jump_E = 0; call_E = 0; ret_E = 0; actual_E = 0; taken_pred_E = 0;
    pred_target_E = 0; pc_E = 0; pc_target_E = 0; pc4_E = 0; ghr_E = 0; ras_ptr_E = 0;
  endtask

  task automatic set_f(input logic [31:0] pc);
    pc_F = pc; pc4_F = pc + 32'd4;
  endtask

  task automatic e_br(input logic [31:0] pc, input logic act, input logic tp,
                      input logic [31:0] ptgt, input logic [31:0] tgt,
                      input logic [GB-1:0] g, input logic [PB-1:0] rp);
    e_idle();
    branch_E = 1; actual_E = act; taken_pred_E = tp; pred_target_E = ptgt;
    pc_E = pc; pc_target_E = tgt; pc4_E = pc + 32'd4; ghr_E = g; ras_ptr_E = rp;
  endtask

  task automatic e_jmp(input logic [31:0] pc, input logic c, input logic r, input logic tp,
                       input logic [31:0] ptgt, input logic [31:0] tgt,
                       input logic [GB-1:0] g, input logic [PB-1:0] rp);
    e_idle();
    jump_E = 1; call_E = c; ret_E = r; taken_pred_E = tp; pred_target_E = ptgt;
    pc_E = pc; pc_target_E = tgt; pc4_E = pc + 32'd4; ghr_E = g; ras_ptr_E = rp;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // ---- reset
    rst = 1; stall_F = 0; e_idle(); set_f(32'h100);
    next_cycle(); next_cycle();
    rst = 0; #1;
    chk("rst_taken",   32'(taken_F),    32'd0);
    chk("rst_pc_next", pc_next,         32'h104);
    chk("rst_ghr",     32'(ghr_F),      32'd0);
    chk("rst_rasptr",  32'(ras_ptr_F),  32'd0);
    chk("rst_flush",   32'(flush),      32'd0);
    chk("rst_restore", pc_restore,      32'd0);
    next_cycle();

    // ---- cold taken branch at 0x200 -> 0x300; F reads same entry this cycle
    e_br(32'h200, 1, 0, 32'h204, 32'h300, 8'hFF, 3'd0); set_f(32'h200); #1;
    chk("cold_flush",   32'(flush),   32'd1);
    chk("cold_restore", pc_restore,   32'h300);
    chk("cold_prewrite_taken", 32'(taken_F), 32'd0);
    next_cycle();
    // ghr_spec = {FF[6:0],1} = FF; PHT[0x80^0xFF] trained to 2
    e_idle(); set_f(32'h200); #1;
    chk("cold_hit_taken", 32'(taken_F), 32'd1);
    chk("cold_hit_next",  pc_next,      32'h300);
    chk("cold_hit_ghr",   32'(ghr_F),   32'hFF);
    chk("cold_hit_flush", 32'(flush),   32'd0);
    next_cycle();

    // ---- loop branch at 0x40 (PHT index 0x10 with ghr 0)
    set_f(32'h100);
    e_br(32'h40, 1, 0, 32'h44, 32'h20, 8'h00, 3'd0); #1;   // ctr 1->2
    chk("loop1_flush",   32'(flush), 32'd1);
    chk("loop1_restore", pc_restore, 32'h20);
    next_cycle();
    e_br(32'h40, 1, 1, 32'h20, 32'h20, 8'h00, 3'd0); #1;   // ctr 2->3
    chk("loop2_flush", 32'(flush), 32'd0);
    next_cycle();
    e_br(32'h40, 1, 1, 32'h20, 32'h20, 8'h00, 3'd0); #1;   // ctr stays 3
    chk("loop3_flush", 32'(flush), 32'd0);
    next_cycle();
    e_br(32'h40, 0, 1, 32'h20, 32'h20, 8'h00, 3'd0); #1;   // ctr 3->2, ghr={0,0}
    chk("loop_exit_flush",   32'(flush), 32'd1);
    chk("loop_exit_restore", pc_restore, 32'h44);
    next_cycle();
    // stalled fetch: predicted taken, no history update
    e_idle(); set_f(32'h40); stall_F = 1; #1;
    chk("loop_ghr_repaired", 32'(ghr_F),   32'd0);
    chk("loop_ctr2_taken",   32'(taken_F), 32'd1);
    chk("loop_ctr2_next",    pc_next,      32'h20);
    next_cycle();
    stall_F = 0; #1;
    chk("loop_unstall_taken", 32'(taken_F), 32'd1);
    next_cycle();
    set_f(32'h100); #1;
    chk("loop_ghr_shift1", 32'(ghr_F), 32'h01);
    next_cycle();
    // a second not-taken: ctr 2->1, which a wrapping counter would not reach
    e_br(32'h40, 0, 1, 32'h20, 32'h20, 8'h00, 3'd0); #1;
    chk("loop_nt2_flush", 32'(flush), 32'd1);
    next_cycle();
    e_idle(); set_f(32'h40); #1;
    chk("loop_ctr1_taken", 32'(taken_F), 32'd0);
    chk("loop_ctr1_next",  pc_next,      32'h44);
    next_cycle();

    // ---- CALL 0x1000 -> 0x2000, RET at 0x2010
    set_f(32'h100);
    e_jmp(32'h1000, 1, 0, 0, 32'h0, 32'h2000, 8'h00, 3'd0); #1;  // ptr 1, cnt 1
    chk("call_train_restore", pc_restore, 32'h2000);
    next_cycle();
    e_jmp(32'h2010, 0, 1, 0, 32'h0, 32'h1004, 8'h00, 3'd1); #1;  // ptr 0, cnt 0
    chk("ret_train_restore", pc_restore, 32'h1004);
    next_cycle();
    e_idle(); set_f(32'h1000); #1;
    chk("call_f_taken",  32'(taken_F),   32'd1);
    chk("call_f_next",   pc_next,        32'h2000);
    chk("call_f_rasptr", 32'(ras_ptr_F), 32'd0);
    next_cycle();
    set_f(32'h2010); #1;
    chk("ret_f_next",   pc_next,        32'h1004);
    chk("ret_f_rasptr", 32'(ras_ptr_F), 32'd1);
    next_cycle();

    // ---- RAS_DEPTH+1 nested calls trained in E (each pushes pc+4)
    set_f(32'h100);
    for (int k = 0; k < 9; k++) begin
      e_jmp(32'h3000 + 32'h100 * k, 1, 0, 0, 32'h0, 32'h5000, 8'h00, PB'(k % 8)); #1;
      chk("nest_call_flush", 32'(flush), 32'd1);
      next_cycle();
    end
    // unwind: 8 surviving entries newest first, then empty -> BTB target
    e_idle();
    for (int j = 0; j < 9; j++) begin
      set_f(32'h2010); #1;
      chk("nest_ret_next",   pc_next,        (j < 8) ? (32'h3804 - 32'h100 * j) : 32'h1004);
      chk("nest_ret_rasptr", 32'(ras_ptr_F), 32'((1 - j) & 7));
      next_cycle();
    end

    // ---- wrong-path speculation then repair
    set_f(32'h3000); #1;                                   // CALL site, push -> ptr 2
    chk("wp_call1_next", pc_next, 32'h5000);
    next_cycle();
    #1; chk("wp_call2_rasptr", 32'(ras_ptr_F), 32'd2);     // push -> ptr 3
    next_cycle();
    // flush this cycle must override the F push that would make ptr 4
    e_br(32'h40, 0, 1, 32'h20, 32'h20, 8'h5A, 3'd3); #1;
    chk("wp_flush_restore", pc_restore, 32'h44);
    next_cycle();
    e_idle(); set_f(32'h100); #1;
    chk("wp_ghr_repair",    32'(ghr_F),     32'hB4);
    chk("wp_rasptr_repair", 32'(ras_ptr_F), 32'd3);
    next_cycle();
    e_jmp(32'h3000, 1, 0, 0, 32'h0, 32'h5000, 8'h33, 3'd5); #1;
    chk("wp_call_flush", 32'(flush), 32'd1);
    next_cycle();
    e_idle(); #1;
    chk("wp_call_ghr",    32'(ghr_F),     32'h33);
    chk("wp_call_rasptr", 32'(ras_ptr_F), 32'd6);
    next_cycle();

    // ---- aliasing: 0x600 and 0x1600 share BTB index 0x180
    e_jmp(32'h600, 0, 0, 0, 32'h0, 32'h700, 8'h33, 3'd6); #1;
    chk("alias_a_flush", 32'(flush), 32'd1);
    next_cycle();
    e_jmp(32'h1600, 0, 0, 1, 32'h700, 32'h800, 8'h33, 3'd6); #1;
    chk("alias_b_restore", pc_restore, 32'h800);
    next_cycle();
    e_jmp(32'h1600, 0, 0, 1, 32'h800, 32'h800, 8'h33, 3'd6); #1;
    chk("jmp_ok_flush",   32'(flush), 32'd0);
    chk("jmp_ok_restore", pc_restore, 32'd0);
    next_cycle();
    e_idle(); set_f(32'h600); #1;
    chk("alias_a_taken", 32'(taken_F), 32'd0);
    chk("alias_a_next",  pc_next,      32'h604);
    next_cycle();
    set_f(32'h1600); #1;
    chk("alias_b_taken", 32'(taken_F), 32'd1);
    chk("alias_b_next",  pc_next,      32'h800);
    next_cycle();

    // ---- reset in mid-operation discards everything
    rst = 1;
    next_cycle();
    rst = 0; #1;
    chk("rst2_taken",  32'(taken_F),   32'd0);
    chk("rst2_next",   pc_next,        32'h1604);
    chk("rst2_ghr",    32'(ghr_F),     32'd0);
    chk("rst2_rasptr", 32'(ras_ptr_F), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
